am2940_dma_seq: RTL and testbench

Sequencer and two-port round-robin arbiter for the am2940 DMA address generator. It accepts transfer requests from two requesters. It issues the am2940 instruction sequence (write control, load address, load word count, enable counters) on the am2940 I/D_IN pins and waits for the am2940 DONE flag. It then returns a per-requester completion pulse. It sits between bus-master clients and am2940_top and is the only driver of am2940 I, D_IN, ACI, WCI and nOEA.

---
 rtl/am2940_pkg.sv | 28 ++
 rtl/am2940_rr_arb.sv | 35 +++
 rtl/am2940_dma_seq.sv | 205 ++++++++++++++++++++
 tb/tb_am2940_dma_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/am2940_pkg.sv
// Shared definitions for the am2940 DMA sequencer.
// Contents: am2940 instruction encodings, the sequencer state enum and the
// default data and control widths.
package am2940_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_CTRL_W = 3;

  // am2940 instruction encodings on the I pins
  localparam logic [2:0] I_WRCR   = 3'b000;  // write control register
  localparam logic [2:0] I_RDCR   = 3'b001;  // read control register (used as NOP)
  localparam logic [2:0] I_RDWC   = 3'b010;  // read word counter
  localparam logic [2:0] I_RDAC   = 3'b011;  // read address counter
  localparam logic [2:0] I_REINIT = 3'b100;  // reinitialize counters
  localparam logic [2:0] I_LDAD   = 3'b101;  // load address
  localparam logic [2:0] I_LDWC   = 3'b110;  // load word count
  localparam logic [2:0] I_ENCT   = 3'b111;  // enable counters

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_CTRL = 3'd1,
    S_LD_ADDR = 3'd2,
    S_LD_CNT  = 3'd3,
    S_RUN     = 3'd4,
    S_FINISH  = 3'd5
  } seq_state_e;

endpackage

// File: rtl/am2940_rr_arb.sv
// Two-way round-robin pick for the am2940 sequencer.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req          : request per requester
//   i_upd          : record i_owner as the last served requester
//   i_owner        : requester that just completed
//   o_pick         : index of the winning requester (valid when |i_req)
module am2940_rr_arb (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  input  logic       i_owner,
  output logic       o_pick
);

  // Index of the last requester served. Resets to 1 so requester 0 wins
  // the first tie.
  logic r_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_last <= 1'b1;
    else if (i_upd) r_last <= i_owner;
  end

  always_comb begin
    o_pick = 1'b0;
    case (i_req)
      2'b10:   o_pick = 1'b1;
      2'b11:   o_pick = ~r_last;
      default: o_pick = 1'b0;
    endcase
  end

endmodule

// File: rtl/am2940_dma_seq.sv
// Sequencer and two-port round-robin arbiter in front of an am2940 DMA
// address generator. A granted request is snapshotted and played out as
// WRCR, LDAD, LDWC, ENCT. The block then waits for am_DONE and pulses done
// to the owner.
// Ports:
//   TRANS, res         : clock (rising edge), asynchronous active-low reset
//   req/req_ctrl/
//   req_addr/req_cnt   : per-requester request level and transfer parameters
//   grant, done, busy  : one-hot owner, completion pulse, non-idle flag
//   am_I, am_D, am_ACI,
//   am_WCI, am_nOEA    : am2940 control pins (this block is their only driver)
//   am_DONE            : am2940 DONE flag, only looked at in RUN
//   err                : sticky RUN timeout (AM2940_SEQ_TIMEOUT_EN only)
//   dbg_state          : current sequencer state
// Optional feature macro: AM2940_SEQ_TIMEOUT_EN adds a TO_W-bit RUN timeout
// counter and the err output.
// Outputs are registered from the current state, so each output lags its
// state by one clock.
module am2940_dma_seq
  import am2940_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int TO_W   = 8
) (
  input  logic                TRANS,
  input  logic                res,
  input  logic [1:0]          req,
  input  logic [2*CTRL_W-1:0] req_ctrl,
  input  logic [2*DATA_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_cnt,
  output logic [1:0]          grant,
  output logic [1:0]          done,
  output logic                busy,
  output logic [2:0]          am_I,
  output logic [DATA_W-1:0]   am_D,
  output logic                am_ACI,
  output logic                am_WCI,
  output logic                am_nOEA,
  input  logic                am_DONE,
`ifdef AM2940_SEQ_TIMEOUT_EN
  output logic                err,
`endif
  output logic [2:0]          dbg_state
);

  if (CTRL_W > DATA_W) begin : g_bad_ctrl_w
    $error("am2940_dma_seq: CTRL_W must not exceed DATA_W");
  end
  if (TO_W < 1) begin : g_bad_to_w
    $error("am2940_dma_seq: TO_W must be at least 1");
  end

  seq_state_e          r_state, w_next;
  logic                r_owner;
  logic [CTRL_W-1:0]   r_ctrl;
  logic [DATA_W-1:0]   r_addr, r_cnt;
  logic                w_pick;
  logic                w_to_hit;

  logic [1:0]          w_grant, w_done, w_own_1h;
  logic                w_busy, w_aci, w_wci, w_noea;
  logic [2:0]          w_I;
  logic [DATA_W-1:0]   w_D;

  am2940_rr_arb u_arb (
    .i_clk   (TRANS),
    .i_rst_n (res),
    .i_req   (req),
    .i_upd   (r_state == S_FINISH),
    .i_owner (r_owner),
    .o_pick  (w_pick)
  );

`ifdef AM2940_SEQ_TIMEOUT_EN
  logic [TO_W-1:0] r_to;
  logic [TO_W-1:0] w_to_inc;
  logic            r_to_flag;
  logic            r_err;

  // The counter holds k-1 in the k-th RUN cycle, so the exit fires when
  // the incremented value reaches all-ones.
  assign w_to_inc = r_to + 1'b1;
  assign w_to_hit = (r_state == S_RUN) && !am_DONE && (&w_to_inc);
  assign err      = r_err;

  always_ff @(posedge TRANS or negedge res) begin
    if (!res) begin
      r_to      <= '0;
      r_to_flag <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (r_state == S_LD_CNT) begin
        r_to      <= '0;
        r_to_flag <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_to <= w_to_inc;
        if (w_to_hit) r_to_flag <= 1'b1;
      end
      // err follows the output pipeline: it rises with done and clears
      // when grant is presented for the next transfer.
      if (r_state == S_WR_CTRL)                  r_err <= 1'b0;
      else if (r_state == S_FINISH && r_to_flag) r_err <= 1'b1;
    end
  end
`else
  assign w_to_hit = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (|req) w_next = S_WR_CTRL;
      S_WR_CTRL: w_next = S_LD_ADDR;
      S_LD_ADDR: w_next = S_LD_CNT;
      S_LD_CNT:  w_next = S_RUN;
      S_RUN:     if (am_DONE || w_to_hit) w_next = S_FINISH;
      S_FINISH:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge TRANS or negedge res) begin
    if (!res) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Snapshot of the winner's parameters. Requester inputs are free to change
  // after this point.
  always_ff @(posedge TRANS or negedge res) begin
    if (!res) begin
      r_owner <= 1'b0;
      r_ctrl  <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
    end else if (r_state == S_IDLE && |req) begin
      r_owner <= w_pick;
      r_ctrl  <= w_pick ? req_ctrl[2*CTRL_W-1 -: CTRL_W] : req_ctrl[CTRL_W-1:0];
      r_addr  <= w_pick ? req_addr[2*DATA_W-1 -: DATA_W] : req_addr[DATA_W-1:0];
      r_cnt   <= w_pick ? req_cnt[2*DATA_W-1 -: DATA_W]  : req_cnt[DATA_W-1:0];
    end
  end

  // Output decode of the current state. The values are registered below.
  assign w_own_1h = r_owner ? 2'b10 : 2'b01;

  always_comb begin
    w_I     = I_RDCR;
    w_D     = '0;
    w_aci   = 1'b0;
    w_wci   = 1'b0;
    w_noea  = 1'b1;
    w_done  = 2'b00;
    w_busy  = (r_state != S_IDLE);
    w_grant = w_busy ? w_own_1h : 2'b00;
    case (r_state)
      S_WR_CTRL: begin
        w_I = I_WRCR;
        w_D = DATA_W'(r_ctrl);
      end
      S_LD_ADDR: begin
        w_I = I_LDAD;
        w_D = r_addr;
      end
      S_LD_CNT: begin
        w_I = I_LDWC;
        w_D = r_cnt;
      end
      S_RUN: begin
        w_I    = I_ENCT;
        w_aci  = 1'b1;
        w_wci  = 1'b1;
        w_noea = 1'b0;
      end
      S_FINISH: w_done = w_own_1h;
      default: ;
    endcase
  end

  always_ff @(posedge TRANS or negedge res) begin
    if (!res) begin
      grant   <= 2'b00;
      done    <= 2'b00;
      busy    <= 1'b0;
      am_I    <= I_RDCR;
      am_D    <= '0;
      am_ACI  <= 1'b0;
      am_WCI  <= 1'b0;
      am_nOEA <= 1'b1;
    end else begin
      grant   <= w_grant;
      done    <= w_done;
      busy    <= w_busy;
      am_I    <= w_I;
      am_D    <= w_D;
      am_ACI  <= w_aci;
      am_WCI  <= w_wci;
      am_nOEA <= w_noea;
    end
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_am2940_dma_seq.sv
// Directed testbench for am2940_dma_seq. Outputs are packed as
// {grant, done, busy, am_I, am_D, am_ACI, am_WCI, am_nOEA} and compared
// against hand-computed vectors, sampled 1 time unit after each rising edge.
module tb_am2940_dma_seq;

  localparam int DW = 4;
  localparam int CW = 3;
`ifdef AM2940_SEQ_TIMEOUT_EN
  localparam int TW = 4;
`else
  localparam int TW = 8;
`endif

  logic          clk = 1'b0;
  logic          res;
  logic [1:0]    req;
  logic [2*CW-1:0] req_ctrl;
  logic [2*DW-1:0] req_addr, req_cnt;
  logic          am_DONE;
  logic [1:0]    grant, done;
  logic          busy, am_ACI, am_WCI, am_nOEA;
  logic [2:0]    am_I;
  logic [DW-1:0] am_D;
  logic [2:0]    dbg_state;
`ifdef AM2940_SEQ_TIMEOUT_EN
  logic          err;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  am2940_dma_seq #(.DATA_W(DW), .CTRL_W(CW), .TO_W(TW)) dut (
    .TRANS    (clk),
    .res      (res),
    .req      (req),
    .req_ctrl (req_ctrl),
    .req_addr (req_addr),
    .req_cnt  (req_cnt),
    .grant    (grant),
    .done     (done),
    .busy     (busy),
    .am_I     (am_I),
    .am_D     (am_D),
    .am_ACI   (am_ACI),
    .am_WCI   (am_WCI),
    .am_nOEA  (am_nOEA),
    .am_DONE  (am_DONE),
`ifdef AM2940_SEQ_TIMEOUT_EN
    .err      (err),
`endif
    .dbg_state(dbg_state)
  );

  logic [14:0] obs;
  assign obs = {grant, done, busy, am_I, am_D, am_ACI, am_WCI, am_nOEA};

  function automatic logic [14:0] mk(input logic [1:0] g, input logic [1:0] d,
                                     input logic b, input logic [2:0] i,
                                     input logic [3:0] dd, input logic aci,
                                     input logic wci, input logic noea);
    return {g, d, b, i, dd, aci, wci, noea};
  endfunction

  function automatic logic [14:0] idle_v();
    return mk(2'b00, 2'b00, 1'b0, 3'b001, 4'h0, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic logic [14:0] run_v(input logic [1:0] g);
    return mk(g, 2'b00, 1'b1, 3'b111, 4'h0, 1'b1, 1'b1, 1'b0);
  endfunction

  function automatic logic [14:0] fin_v(input logic [1:0] g);
    return mk(g, g, 1'b1, 3'b001, 4'h0, 1'b0, 1'b0, 1'b1);
  endfunction

  task automatic chk(input string tag, input logic [14:0] e);
    n_vec++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer, starting with the sequencer in IDLE and req
  // already applied. c is the zero-extended ctrl expected on am_D.
  task automatic xfer(input string tag, input logic [1:0] g, input logic [3:0] c,
                      input logic [3:0] a, input logic [3:0] n, input int run_len,
                      input bit early, input bit drop, input bit no_done);
    if (early) am_DONE = 1'b1;
    tick(); chk({tag, "/idle"}, idle_v());
    tick(); chk({tag, "/wrcr"}, mk(g, 2'b00, 1'b1, 3'b000, c, 1'b0, 1'b0, 1'b1));
    if (drop) begin
      req      = 2'b00;
      req_ctrl = '1;
      req_addr = '1;
      req_cnt  = '1;
    end
    tick(); chk({tag, "/ldad"}, mk(g, 2'b00, 1'b1, 3'b101, a, 1'b0, 1'b0, 1'b1));
    tick(); chk({tag, "/ldwc"}, mk(g, 2'b00, 1'b1, 3'b110, n, 1'b0, 1'b0, 1'b1));
    for (int k = 1; k < run_len; k++) begin
      tick(); chk({tag, "/run"}, run_v(g));
    end
    if (!no_done) am_DONE = 1'b1;
    tick(); chk({tag, "/run_last"}, run_v(g));
    am_DONE = 1'b0;
    tick(); chk({tag, "/finish"}, fin_v(g));
  endtask

  initial begin
    res      = 1'b0;
    req      = 2'b00;
    req_ctrl = '0;
    req_addr = '0;
    req_cnt  = '0;
    am_DONE  = 1'b0;

    // Reset state
    tick(); tick();
    chk("reset", idle_v());
`ifdef AM2940_SEQ_TIMEOUT_EN
    n_vec++;
    assert (err === 1'b0) else begin
      n_fail++; $error("FAIL err_reset: observed %b expected 0", err);
    end
`endif
    res = 1'b1;
    tick(); chk("idle_after_reset", idle_v());

    // Basic transfer on requester 0: ctrl 0, addr 5, cnt 3, DONE after 3 RUN cycles
    req = 2'b01; req_ctrl = 6'o00; req_addr = 8'h05; req_cnt = 8'h03;
    xfer("basic", 2'b01, 4'h0, 4'h5, 4'h3, 4, 1'b0, 1'b0, 1'b0);
    req = 2'b00;
    tick(); chk("basic/done_once", idle_v());
    tick(); chk("basic/idle", idle_v());

    // Tie right after reset: 0 first, then alternation while both held
    res = 1'b0; tick(); res = 1'b1;
    req_ctrl = {3'b011, 3'b101};
    req_addr = {4'h9, 4'h2};
    req_cnt  = {4'h4, 4'h7};
    req = 2'b11;
    xfer("tie0", 2'b01, 4'h5, 4'h2, 4'h7, 2, 1'b0, 1'b0, 1'b0);
    xfer("tie1", 2'b10, 4'h3, 4'h9, 4'h4, 1, 1'b0, 1'b0, 1'b0);
    xfer("tie2", 2'b01, 4'h5, 4'h2, 4'h7, 3, 1'b0, 1'b0, 1'b0);
    xfer("tie3", 2'b10, 4'h3, 4'h9, 4'h4, 2, 1'b0, 1'b0, 1'b0);
    req = 2'b00;
    tick(); chk("tie/idle", idle_v());

    // DONE already high at RUN entry, also held through the load states
    req = 2'b01; req_ctrl = {3'b000, 3'b111}; req_addr = {4'h0, 4'hA}; req_cnt = {4'h0, 4'h1};
    xfer("early", 2'b01, 4'h7, 4'hA, 4'h1, 1, 1'b1, 1'b0, 1'b0);
    req = 2'b00;
    tick(); chk("early/idle", idle_v());

    // Requester 1 drops req during LD_ADDR; snapshot values still used
    req = 2'b10; req_ctrl = {3'b010, 3'b000}; req_addr = {4'hC, 4'h0}; req_cnt = {4'h6, 4'h0};
    xfer("drop", 2'b10, 4'h2, 4'hC, 4'h6, 2, 1'b0, 1'b1, 1'b0);
    tick(); chk("drop/idle", idle_v());

    // Asynchronous reset during RUN
    req = 2'b01; req_ctrl = {3'b000, 3'b001}; req_addr = {4'h0, 4'h3}; req_cnt = {4'h0, 4'h2};
    tick(); chk("arst/idle", idle_v());
    tick(); chk("arst/wrcr", mk(2'b01, 2'b00, 1'b1, 3'b000, 4'h1, 1'b0, 1'b0, 1'b1));
    tick(); chk("arst/ldad", mk(2'b01, 2'b00, 1'b1, 3'b101, 4'h3, 1'b0, 1'b0, 1'b1));
    tick(); chk("arst/ldwc", mk(2'b01, 2'b00, 1'b1, 3'b110, 4'h2, 1'b0, 1'b0, 1'b1));
    tick(); chk("arst/run", run_v(2'b01));
    #2 res = 1'b0;
    #1 chk("arst/immediate", idle_v());
    req = 2'b00;
    tick(); chk("arst/no_done", idle_v());
    res = 1'b1;
    tick(); chk("arst/idle_after", idle_v());

    // Recovery: new request after the aborted transfer
    req = 2'b10; req_ctrl = {3'b100, 3'b000}; req_addr = {4'hF, 4'h0}; req_cnt = {4'h8, 4'h0};
    xfer("recover", 2'b10, 4'h4, 4'hF, 4'h8, 1, 1'b0, 1'b0, 1'b0);
    req = 2'b00;
    tick(); chk("recover/idle", idle_v());

`ifdef AM2940_SEQ_TIMEOUT_EN
    // DONE stuck low: RUN exits after 15 cycles, err rises with done
    req = 2'b01; req_ctrl = {3'b000, 3'b110}; req_addr = {4'h0, 4'h4}; req_cnt = {4'h0, 4'h9};
    xfer("timeout", 2'b01, 4'h6, 4'h4, 4'h9, 15, 1'b0, 1'b0, 1'b1);
    n_vec++;
    assert (err === 1'b1) else begin
      n_fail++; $error("FAIL err_set: observed %b expected 1", err);
    end
    req = 2'b10; req_ctrl = {3'b001, 3'b000}; req_addr = {4'h1, 4'h0}; req_cnt = {4'h1, 4'h0};
    xfer("after_to", 2'b10, 4'h1, 4'h1, 4'h1, 1, 1'b0, 1'b0, 1'b0);
    req = 2'b00;
    n_vec++;
    assert (err === 1'b0) else begin
      n_fail++; $error("FAIL err_clear: observed %b expected 0", err);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
